// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a length/payload/checksum byte frame,
// writes the payload to memory from byte address 0 and keeps the core in reset until a verified load.
module imem_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_dbg
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t        state;
  logic [7:0]    n_words;
  logic [CW-1:0] cnt;
  logic [7:0]    acc;
  logic [9:0]    byte_total;
  logic          last_byte;
  logic          len_bad;
  logic          xfer;

  // Handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready
  // is a pure function of the state register, and the source must hold in_data until taken.
  assign xfer       = in_valid && in_ready;
  assign byte_total = {n_words, 2'b00};
  assign last_byte  = (32'(cnt) == 32'(byte_total) - 32'd1);
  assign len_bad    = (in_data == 8'd0) || (32'(in_data) > DEPTH / 4);
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      n_words   <= 8'd0;
      cnt       <= '0;
      acc       <= 8'd0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
      cpu_hold  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LEN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LEN: begin
          if (xfer) begin
            n_words <= in_data;
            if (len_bad) begin
              state    <= ERR;
              err      <= 1'b1;
              in_ready <= 1'b0;
              busy     <= 1'b0;
            end else begin
              state <= DATA;
              cnt   <= '0;
              acc   <= 8'd0;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= ADDR_W'(cnt);
            mem_wdata <= in_data;
            acc       <= acc ^ in_data;
            cnt       <= cnt + 1'b1;
            if (last_byte) state <= CSUM;
          end
        end
        CSUM: begin
          if (xfer) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == acc) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          // Restart keeps memory contents; only status is cleared.
          if (start) begin
            state    <= LEN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: frames are built from a byte-level
// reference model, expected writes are queued and matched against the memory port.
module tb_imem_loader;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W+7:0] exp_q[$];
  logic [7:0]        tb_mem[DEPTH];
  logic [7:0]        ref_mem[DEPTH];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%0h:%0h required=none", mem_addr, mem_wdata);
      end else begin
        logic [ADDR_W+7:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          failures++;
          $display("FAIL write actual=%0h:%0h required=%0h:%0h",
                   mem_addr, mem_wdata, e[ADDR_W+7:8], e[7:0]);
        end
      end
      if (mem_addr < DEPTH) tb_mem[mem_addr] = mem_wdata;
    end
  end

  // Driver tasks
  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int guard;
    guard = 0;
    if (gap) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Reference model: a frame is legal for 1..DEPTH/4 words; payload lands at bytes
  // 0..4N-1 whatever the checksum; success only when checksum equals XOR of payload.
  task automatic run_frame(input int n, input logic [7:0] pl[16], input logic [7:0] cs,
                           input bit throttle, input bit mid_start);
    logic [7:0] x;
    bit legal;
    bit good;
    pulse_start();
    legal = (n >= 1) && (n <= DEPTH / 4);
    send_byte(8'(n), throttle);
    if (!legal) begin
      check("len_err", 40'(err), 40'd1);
      check("len_done", 40'(done), 40'd0);
      check("len_hold", 40'(cpu_hold), 40'd1);
      check("len_busy", 40'(busy), 40'd0);
      check("len_ready", 40'(in_ready), 40'd0);
      return;
    end
    check("load_busy", 40'(busy), 40'd1);
    check("load_hold", 40'(cpu_hold), 40'd1);
    x = 8'd0;
    for (int i = 0; i < 4 * n; i++) begin
      exp_q.push_back({32'(i), pl[i]});
      ref_mem[i] = pl[i];
      x = x ^ pl[i];
      send_byte(pl[i], throttle);
      if (mid_start && i == 5) pulse_start();
    end
    send_byte(cs, throttle);
    good = (cs == x);
    check("end_done", 40'(done), 40'(good));
    check("end_err", 40'(err), 40'(!good));
    check("end_hold", 40'(cpu_hold), 40'(!good));
    check("end_busy", 40'(busy), 40'd0);
    check("end_ready", 40'(in_ready), 40'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 40'(in_ready), 40'd0);
    check({tag, "_we"}, 40'(mem_we), 40'd0);
    check({tag, "_addr"}, 40'(mem_addr), 40'd0);
    check({tag, "_wdata"}, 40'(mem_wdata), 40'd0);
    check({tag, "_hold"}, 40'(cpu_hold), 40'd1);
    check({tag, "_busy"}, 40'(busy), 40'd0);
    check({tag, "_done"}, 40'(done), 40'd0);
    check({tag, "_err"}, 40'(err), 40'd0);
  endtask

  initial begin
    logic [7:0] pl[16];
    logic [7:0] good_pl[16];
    logic [7:0] x;
    int n;

    good_pl = '{8'h03, 8'hA3, 8'hC4, 8'hFF, 8'h23, 8'hA4, 8'h64, 8'h00,
                8'h33, 8'hE2, 8'h62, 8'h00, 8'hE3, 8'h0A, 8'h42, 8'hFE};
    for (int a = 0; a < DEPTH; a++) begin
      tb_mem[a]  = 8'h00;
      ref_mem[a] = 8'h00;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    apply_reset();
    #1 check_reset_values("rst");

    run_frame(4, good_pl, 8'h9E, 1'b0, 1'b0);
    run_frame(4, good_pl, 8'h9F, 1'b0, 1'b0);
    run_frame(0, good_pl, 8'h00, 1'b0, 1'b0);
    run_frame(5, good_pl, 8'h00, 1'b0, 1'b0);
    run_frame(4, good_pl, 8'h9E, 1'b0, 1'b0);
    run_frame(4, good_pl, 8'h9E, 1'b1, 1'b1);

    // Abort after six payload bytes; the sixth write is seen before reset drops.
    pulse_start();
    send_byte(8'd4, 1'b0);
    for (int i = 0; i < 6; i++) begin
      pl[i] = 8'($urandom_range(0, 255));
      exp_q.push_back({32'(i), pl[i]});
      ref_mem[i] = pl[i];
      send_byte(pl[i], 1'b0);
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_values("abort");
    check("abort_q_empty", 40'(exp_q.size()), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(4, good_pl, 8'h9E, 1'b0, 1'b0);

    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(0, 5);
      x = 8'd0;
      for (int i = 0; i < 16; i++) begin
        pl[i] = 8'($urandom_range(0, 255));
        if (i < 4 * n) x = x ^ pl[i];
      end
      if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
      run_frame(n, pl, x, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("final_q_empty", 40'(exp_q.size()), 40'd0);
    for (int a = 0; a < DEPTH; a++) check("mem_contents", 40'(tb_mem[a]), 40'(ref_mem[a]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the processor's byte-addressed instruction memory. It accepts a framed byte stream over a valid/ready handshake, writes each payload byte into instruction memory at consecutive byte addresses starting at 0, and verifies a trailing XOR checksum. While a load is in progress or has failed, it holds the core in reset. The core is released only after a verified load, so fetch never sees a half-written program.

## Interface

Parameters:
- DEPTH, 16, instruction memory size in bytes; must be a multiple of 4; max words = DEPTH/4.
- ADDR_W, 32, width of the memory byte address.

Ports:
- clk, input, 1, single clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request to begin a load.
- in_valid, input, 1, in_data holds a byte.
- in_data, input, 8, stream byte.
- in_ready, output, 1, loader can accept a byte this cycle.
- mem_we, output, 1, byte write strobe to instruction memory.
- mem_addr, output, ADDR_W, byte address for the write.
- mem_wdata, output, 8, byte to write.
- cpu_hold, output, 1, high means the core is held in reset.
- busy, output, 1, load in progress.
- done, output, 1, last load completed with a good checksum.
- err, output, 1, last load was rejected.

## Operation

- **Frame format:** one length byte N (word count), then 4N payload bytes, then one checksum byte.
  - Payload is little-endian per word: the byte at address 4k is the LSB of word k.
  - The checksum equals the XOR of all 4N payload bytes. The length byte is not included.
- **States:** IDLE, LEN, DATA, CSUM, DONE, ERR.
- **IDLE → LEN:** on start.
- **LEN:**
  - On accept, N is latched.
  - If N == 0 or N > DEPTH/4, go to ERR.
  - Otherwise go to DATA. The byte counter and address are cleared to 0 and the checksum accumulator is cleared to 0.
- **DATA:**
  - Each accepted byte is XORed into the accumulator and issues one memory write.
  - The address increments by 1 per byte.
  - After byte 4N−1 is accepted, go to CSUM.
- **CSUM:**
  - If the accepted byte equals the accumulator, go to DONE; otherwise go to ERR.
  - No memory write is issued for the checksum byte.
- **DONE / ERR:**
  - in_ready is low.
  - start re-enters LEN with done and err cleared; memory contents are not erased.
- start in LEN, DATA or CSUM is ignored.
- in_valid while in_ready is low is ignored; no byte is consumed.
- Bytes beyond 4N cannot be accepted as payload. The byte after the payload is always taken as the checksum.
- Memory is never cleared by this block. Bytes above 4N−1 keep their prior contents.

## Timing

- **Transfer:** occurs when in_valid && in_ready at a rising edge.
  - in_ready is decoded from the state register only: high in LEN, DATA and CSUM.
  - There is no combinational path from in_valid to in_ready.
  - Full throughput is one byte per cycle.
- **Write latency:** 1 cycle. A DATA byte accepted at edge t appears with mem_we=1 and its mem_addr/mem_wdata during cycle t+1.
  - mem_we is a one-cycle pulse per byte.
  - mem_addr and mem_wdata hold their last value when mem_we=0.
- **done / err:** set at the edge that enters DONE or ERR, together with the state change.
- **cpu_hold:**
  - Low only in DONE; high in all other states.
  - On a good load it falls on the edge entering DONE, which is one cycle after the final payload write is issued. The write completes before the core leaves reset.
- **busy:** high in LEN, DATA and CSUM.
- **Reset values:** state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, busy 0, done 0, err 0; counter, N and accumulator all 0.
- **Reset mid-load:**
  - Asserting rst_n low aborts the load immediately, without waiting for a clock edge.
  - A pending mem_we is dropped.
  - Bytes already written stay in memory.
- **Counter widths:** sized for 4·(DEPTH/4) bytes. The address never wraps, because the length check bounds it to DEPTH−1.

## Test plan

- **Good 4-word load:** after start, send N=04, then bytes 03 A3 C4 FF 23 A4 64 00 33 E2 62 00 E3 0A 42 FE, then checksum 9E, with in_valid held high.
  - Expect 16 mem_we pulses at addresses 0..15 with matching data.
  - done=1, err=0 and cpu_hold=0 one cycle after the checksum edge.
- **Bad checksum:** same frame with checksum 9F.
  - Expect all 16 writes, then err=1, done=0, cpu_hold stays 1.
- **Illegal length:** send N=00 and, separately, N=05 with DEPTH=16.
  - Expect ERR on the next edge and no mem_we.
  - Then start followed by a good frame ends in done=1.
- **Throttled source:** same good frame with in_valid toggling 1,0,1,0 and start pulsed mid-load.
  - Expect identical writes, the ignored start has no effect, and the load ends in done.
- **Reset mid-load:** assert rst_n low after 6 payload bytes.
  - All outputs return to their reset values at once.
  - Addresses 0..5 hold the written bytes.
  - A new start and full frame completes normally.
